// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared FSM encoding and default sizes for the ccff chain loader
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } ccff_state_e;

  localparam int DEFAULT_WORD_W    = 8;
  localparam int DEFAULT_CHAIN_LEN = 1024;

endpackage

// File: rtl/ccff_deser.sv
// rtl/ccff_deser.sv - packs the serial chain-tail stream LSB-first into words
// flush_i emits a partially filled word (MSBs zero) together with any bit arriving that cycle.
module ccff_deser
  import ccff_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              ser_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o
);

  localparam int CW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] word_q, word_d, data_q, data_d, acc;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_n;
  logic              valid_q, valid_d;

  always_comb begin
    acc     = word_q;
    cnt_n   = cnt_q;
    if (en_i) begin
      acc   = word_q | (WORD_W'(ser_i) << cnt_q);
      cnt_n = cnt_q + 1'b1;
    end
    word_d  = acc;
    cnt_d   = cnt_n;
    data_d  = data_q;
    valid_d = 1'b0;
    if ((cnt_n == CW'(WORD_W)) || (flush_i && (cnt_n != '0))) begin
      data_d  = acc;
      valid_d = 1'b1;
      word_d  = '0;
      cnt_d   = '0;
    end
    // A new or cancelled load must not inherit bits from the previous one.
    if (clr_i) begin
      word_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - ccff chain master: serialises words LSB-first onto ccff_head for CHAIN_LEN bits
// Define CCFF_READBACK_EN to pack ccff_tail into rb_data/rb_valid during a load.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              cfg_done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);

  ccff_state_e       state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   wbit_q, wbit_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              cfg_en_q, cfg_en_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    wbit_d     = wbit_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    cfg_en_d   = cfg_en_q;
    done_d     = done_q;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          bit_cnt_d = '0;
          cfg_en_d  = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          wbit_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy       = 1'b1;
        head_d     = sreg_q[0];
        shift_en_d = 1'b1;
        sreg_d     = sreg_q >> 1;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        wbit_d     = wbit_q + 1'b1;
        // Chain length wins over word boundary: leftover word bits are dropped.
        if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
          state_d = ST_DONE;
        end else if (wbit_d == WB_W'(WORD_W)) begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        busy     = 1'b1;
        cfg_en_d = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
    if (abort) begin
      in_ready   = 1'b0;
      state_d    = ST_IDLE;
      cfg_en_d   = 1'b0;
      shift_en_d = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      wbit_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      cfg_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      wbit_q     <= wbit_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      cfg_en_q   <= cfg_en_d;
      done_q     <= done_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign config_enable = cfg_en_q;
  assign cfg_done      = done_q;

`ifdef CCFF_READBACK_EN
  // The tail bit visible while shift_en is high is the old content about to leave the chain.
  ccff_deser #(
    .WORD_W(WORD_W)
  ) u_deser (
    .clk_i  (prog_clk),
    .rst_i  (pReset),
    .clr_i  (abort | ((state_q == ST_IDLE) & start)),
    .en_i   (shift_en_q),
    .ser_i  (ccff_tail),
    .flush_i(state_q == ST_DONE),
    .data_o (rb_data),
    .valid_o(rb_valid)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader (WORD_W=8, CHAIN_LEN=20)
module tb_ccff_chain_loader;

  localparam int WW = 8;
  localparam int CL = 20;

  logic          prog_clk = 1'b0;
  logic          pReset, start, abort, in_valid;
  logic [WW-1:0] in_data;
  logic          in_ready, ccff_head, ccff_shift_en, config_enable, ccff_tail, busy, cfg_done;
`ifdef CCFF_READBACK_EN
  logic [WW-1:0] rb_data;
  logic          rb_valid;
  logic [WW-1:0] rb_exp [4];
  logic [WW-1:0] rb_first, rb_last;
  int            rb_n, rb_idx;
`endif

  ccff_chain_loader #(
    .WORD_W   (WW),
    .CHAIN_LEN(CL)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .abort        (abort),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .config_enable(config_enable),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .cfg_done     (cfg_done)
`ifdef CCFF_READBACK_EN
    ,
    .rb_data      (rb_data),
    .rb_valid     (rb_valid)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Model of the tile chain: bit CL-1 is the deepest (nearest the tail).
  logic [CL-1:0] chain;
  logic          preload, preload_val;
  always @(posedge prog_clk) begin
    if (preload) chain <= preload_val ? '1 : '0;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  int            checks, errors;
  logic          exp_bits [CL];
  logic [CL-1:0] img;
  int            rd_ptr, shift_seen, bubbles;
  logic          prev_stall, stall_watch, last_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic prepare_model(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2);
    logic [WW-1:0] wq [3];
    wq[0] = w0; wq[1] = w1; wq[2] = w2;
    img = '0;
    for (int k = 0; k < CL; k++) begin
      exp_bits[k]   = wq[k / WW][k % WW];
      img[CL-1-k]   = wq[k / WW][k % WW];
    end
    rd_ptr = 0; shift_seen = 0; bubbles = 0;
`ifdef CCFF_READBACK_EN
    for (int j = 0; j < 4; j++) rb_exp[j] = '0;
    for (int j = 0; j < CL; j++) rb_exp[j / WW][j % WW] = chain[CL-1-j];
    rb_n = (CL + WW - 1) / WW;
    rb_idx = 0;
`endif
  endtask

  task automatic compare();
    if (ccff_shift_en === 1'b1) begin
      check("cfg_en_during_shift", config_enable, 1);
      if (rd_ptr < CL) check("ccff_head", ccff_head, exp_bits[rd_ptr]);
      else check("shift_overrun", rd_ptr, CL - 1);
      rd_ptr++;
      shift_seen++;
    end else if (config_enable === 1'b1 && shift_seen > 0 && rd_ptr < CL) begin
      bubbles++;
    end
    if (prev_stall) begin
      check("stall_hold_shift", ccff_shift_en, 0);
      check("stall_cfg_en", config_enable, 1);
    end
`ifdef CCFF_READBACK_EN
    if (rb_valid === 1'b1) begin
      if (rb_idx < rb_n) check("rb_data", rb_data, rb_exp[rb_idx]);
      else check("rb_overrun", rb_idx, rb_n - 1);
      if (rb_idx == 0) rb_first = rb_data;
      rb_last = rb_data;
      rb_idx++;
    end
`endif
  endtask

  task automatic cyc();
    @(negedge prog_clk);
    compare();
    last_hs    = in_valid && in_ready;
    prev_stall = stall_watch && in_ready && !in_valid;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_load(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input logic [WW-1:0] w2,
                         input int stall_len, input int abort_at, input bit mid_start);
    logic [WW-1:0] wq [3];
    int idx, stalled, guard;
    bit aborted;
    wq[0] = w0; wq[1] = w1; wq[2] = w2;
    prepare_model(w0, w1, w2);
    idx = 0; stalled = 0; guard = 0; aborted = 0;
    in_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    stall_watch = (stall_len > 0);
    while (!cfg_done && !aborted && guard < 400) begin
      in_data  = wq[idx < 3 ? idx : 2];
      in_valid = (idx < 3) && !(idx == 1 && stalled < stall_len);
      start    = mid_start && (shift_seen == 5);
      abort    = (abort_at >= 0) && ccff_shift_en && (shift_seen == abort_at);
      aborted  = abort;
      cyc();
      abort = 1'b0;
      start = 1'b0;
      if (last_hs) idx++;
      if (prev_stall) stalled++;
      guard++;
    end
    in_valid = 1'b0;
    stall_watch = 1'b0;
    if (aborted) begin
      check("abort_cfg_en", config_enable, 0);
      check("abort_shift_en", ccff_shift_en, 0);
      check("abort_cfg_done", cfg_done, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_busy", busy, 0);
      check("abort_bits_shifted", shift_seen, abort_at + 1);
    end else begin
      check("load_done", cfg_done, 1);
      cyc();
      check("shift_count", shift_seen, CL);
      check("bubbles", bubbles, (CL + WW - 1) / WW - 1 + stall_len);
      check("stream_consumed", rd_ptr, CL);
      check("cfg_done_sticky", cfg_done, 1);
      check("done_cfg_en", config_enable, 0);
      check("done_busy", busy, 0);
      check("done_shift_en", ccff_shift_en, 0);
      check("chain_image", chain, img);
`ifdef CCFF_READBACK_EN
      check("rb_count", rb_idx, rb_n);
`endif
    end
  endtask

  initial begin
    int guard;
    checks = 0; errors = 0;
    pReset = 1'b1; start = 1'b0; abort = 1'b0; in_data = '0; in_valid = 1'b0;
    preload = 1'b1; preload_val = 1'b0;
    prev_stall = 1'b0; stall_watch = 1'b0; last_hs = 1'b0;
    rd_ptr = CL; shift_seen = 0; bubbles = 0;
    repeat (2) @(posedge prog_clk);
    #1;
    pReset = 1'b0; preload = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_shift_en", ccff_shift_en, 0);
    check("rst_cfg_en", config_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_done", cfg_done, 0);

    do_load(8'hA5, 8'h3C, 8'h0F, 0, -1, 1'b0);
    check("chain_literal_basic", chain, 32'hA53CF);

    do_load(8'hA5, 8'h3C, 8'h0F, 5, -1, 1'b0);
    check("chain_literal_stall", chain, 32'hA53CF);

    do_load(8'h5A, 8'hC3, 8'h81, 0, -1, 1'b0);
    check("chain_literal_alt", chain, 32'h5AC38);

    do_load(8'hA5, 8'h3C, 8'h0F, 0, 10, 1'b0);
    cyc();
    do_load(8'hA5, 8'h3C, 8'h0F, 0, -1, 1'b0);
    check("chain_literal_after_abort", chain, 32'hA53CF);

    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    check("start_abort_cfg_en", config_enable, 0);
    check("start_abort_busy", busy, 0);
    check("start_abort_in_ready", in_ready, 0);
    do_load(8'h5A, 8'hC3, 8'h81, 0, -1, 1'b1);
    check("chain_literal_mid_start", chain, 32'h5AC38);

    prepare_model(8'hA5, 8'h3C, 8'h0F);
    start = 1'b1;
    cyc();
    start = 1'b0;
    in_data = 8'hA5; in_valid = 1'b1;
    guard = 0;
    while (shift_seen < 4 && guard < 50) begin
      cyc();
      guard++;
    end
    check("reset_reached_shift", shift_seen, 4);
    pReset = 1'b1;
    cyc();
    pReset = 1'b0;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_head", ccff_head, 0);
    check("mid_rst_shift_en", ccff_shift_en, 0);
    check("mid_rst_cfg_en", config_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfg_done", cfg_done, 0);
    repeat (4) begin
      cyc();
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_cfg_en", config_enable, 0);
      check("post_rst_shift_en", ccff_shift_en, 0);
    end
    in_valid = 1'b0;

`ifdef CCFF_READBACK_EN
    preload = 1'b1; preload_val = 1'b1;
    cyc();
    preload = 1'b0;
    do_load(8'h00, 8'h00, 8'h00, 0, -1, 1'b0);
    check("rb_first_literal", rb_first, 8'hFF);
    check("rb_last_literal", rb_last, 8'h0F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Master end of the configuration-chain (ccff) protocol.
- Accepts configuration words from the bitstream source over a valid/ready stream and serialises them LSB-first onto ccff_head, one bit per shift-enable cycle.
- Drives config_enable for the tile chain and counts exactly CHAIN_LEN bits.
- Sits between the bitstream port and the first tile's ccff_head input; ccff_tail of the last tile returns to this block.

Parameters:
- WORD_W, 8, width of one input configuration word.
- CHAIN_LEN, 1024, total bits in the ccff chain (≥1).
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived, not overridden).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a load.
- abort  in  1  one-cycle pulse: cancel the load in progress.
- in_data  in  WORD_W  configuration word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- ccff_head  out  1  serial bit to the chain head.
- ccff_shift_en  out  1  chain advances one bit at the next prog_clk edge.
- config_enable  out  1  chain is in programming mode.
- ccff_tail  in  1  serial bit returned from the chain tail.
- busy  out  1  load in progress.
- cfg_done  out  1  sticky: last load completed with all CHAIN_LEN bits shifted.

Behaviour:
- Reset (pReset=1 at an edge): state IDLE. All outputs 0, shift register 0, bit_cnt 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - On start: clear cfg_done and bit_cnt, set config_enable=1, go to LOAD.
- LOAD:
  - in_ready=1, busy=1, ccff_shift_en=0. The chain holds while in_valid is low; stalls are unbounded.
  - On in_valid&in_ready: capture in_data into sreg, set wbit=0, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle, registered: ccff_head<=sreg[0], ccff_shift_en<=1, sreg<=sreg>>1, bit_cnt++, wbit++.
  - When bit_cnt reaches CHAIN_LEN: go to DONE. Any remaining bits of the current word are discarded.
  - Otherwise, when wbit reaches WORD_W: go to LOAD.
  - Exactly one idle (non-shift) cycle per word boundary.
- DONE:
  - ccff_shift_en=0 and config_enable=0 on the next edge.
  - Set cfg_done=1, go to IDLE.
  - cfg_done stays high until the next start, pReset or abort.
- Shift count: ccff_shift_en is high on exactly CHAIN_LEN cycles per completed load. ccff_head is always valid on a cycle where ccff_shift_en=1.
- Bit order: word 0 bit 0 is shifted first, so it ends up deepest in the chain (nearest ccff_tail).
- abort: in any state, return to IDLE next edge with config_enable=0, ccff_shift_en=0, cfg_done=0. abort has priority over start and over a handshake in the same cycle.
- start while busy: ignored.
- pReset mid-load: identical to the reset state. Chain contents are undefined; software reloads.
- in_data offered in IDLE, SHIFT or DONE: not accepted (in_ready=0).

Optional Feature:
- Macro CCFF_READBACK_EN.
- Defined:
  - ccff_tail is sampled on every cycle where ccff_shift_en=1 and packed LSB-first into WORD_W-bit words.
  - Extra outputs: rb_data[WORD_W], rb_valid (one-cycle pulse per full word, plus one for a partial final word zero-padded in the MSBs).
  - rb has no backpressure.
  - Readback yields the previous chain contents (first bit out = previous bit nearest the tail).
- Not defined: ccff_tail is ignored, and rb ports are absent.

Decomposition:
- Package ccff_pkg: state enum (IDLE/LOAD/SHIFT/DONE), default WORD_W/CHAIN_LEN constants.
- Sub-module ccff_deser: tail-side packer used under CCFF_READBACK_EN. Serial in + enable produces word + valid. It has a flush input that emits the partial final word.

Test Plan:
- WORD_W=8, CHAIN_LEN=20; start; words 0xA5, 0x3C, 0x0F with in_valid always 1:
  - ccff_head sequence on shift_en cycles is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - Exactly 20 shift_en cycles, 2 bubbles between words.
  - cfg_done=1 after the last shift, config_enable=0.
- Stall: in_valid low for 5 cycles before the second word → ccff_shift_en=0 throughout the stall, config_enable stays 1, final bit sequence unchanged.
- abort asserted during the 3rd bit of word 1 → next edge: IDLE, config_enable=0, ccff_shift_en=0, cfg_done=0, in_ready=0. A subsequent start performs a full 20-bit load.
- start and abort in the same cycle from IDLE → stays IDLE. start while busy → no effect on bit count (still 20).
- pReset asserted mid-SHIFT → all outputs 0 on the next edge. in_valid held high afterwards is not accepted until start.
- CCFF_READBACK_EN: chain model preloaded with 20 ones; load zeros → rb_valid pulses 3 times with rb_data 0xFF, 0xFF, 0x0F.
